// File: rtl/defuzzificador_nie_tan.sv
// Nie-Tan type reducer: folds nine firing intervals into one crisp 8-bit value
// with a 9-cycle multiply-accumulate followed by an 8-step restoring divide.
module defuzzificador_nie_tan #(
    parameter logic [7:0] C1 = 8'd0,
    parameter logic [7:0] C2 = 8'd32,
    parameter logic [7:0] C3 = 8'd64,
    parameter logic [7:0] C4 = 8'd96,
    parameter logic [7:0] C5 = 8'd128,
    parameter logic [7:0] C6 = 8'd160,
    parameter logic [7:0] C7 = 8'd192,
    parameter logic [7:0] C8 = 8'd224,
    parameter logic [7:0] C9 = 8'd255
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        START,
    input  logic [71:0] F_UP,
    input  logic [71:0] F_LOW,
    output logic [7:0]  Saida,
    output logic        DONE,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, ACC, DIV} state_t;

    localparam logic [71:0] C_PACK = {C9, C8, C7, C6, C5, C4, C3, C2, C1};

    state_t      state_reg, state_next;
    logic [71:0] fu_reg, fu_next;
    logic [71:0] fl_reg, fl_next;
    logic [20:0] num_reg, num_next;
    logic [20:0] rem_reg, rem_next;
    logic [12:0] den_reg, den_next;
    logic [3:0]  idx_reg, idx_next;
    logic [2:0]  k_reg, k_next;
    logic [7:0]  q_reg, q_next;
    logic [7:0]  saida_reg, saida_next;
    logic        done_reg, done_next;

    logic [8:0]  w_all [9];
    logic [7:0]  cent  [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_rule
            assign w_all[gi] = {1'b0, fu_reg[8*gi +: 8]} + {1'b0, fl_reg[8*gi +: 8]};
            assign cent[gi]  = C_PACK[8*gi +: 8];
        end
    endgenerate

    logic [8:0]  w_sel;
    logic [7:0]  c_sel;
    logic [16:0] prod;
    logic [20:0] num_acc;
    logic [12:0] den_acc;
    logic [20:0] den_shift;
    logic        bit_set;

    assign w_sel     = w_all[idx_reg];
    assign c_sel     = cent[idx_reg];
    assign prod      = {8'd0, w_sel} * {9'd0, c_sel};
    assign num_acc   = num_reg + {4'd0, prod};
    assign den_acc   = den_reg + {4'd0, w_sel};
    assign den_shift = {8'd0, den_reg} << k_reg;
    // A zero denominator must never set quotient bits, so the result collapses to 0.
    assign bit_set   = (den_reg != 13'd0) && (rem_reg >= den_shift);

    always_comb begin
        state_next = state_reg;
        fu_next    = fu_reg;
        fl_next    = fl_reg;
        num_next   = num_reg;
        rem_next   = rem_reg;
        den_next   = den_reg;
        idx_next   = idx_reg;
        k_next     = k_reg;
        q_next     = q_reg;
        saida_next = saida_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (START) begin
                    fu_next    = F_UP;
                    fl_next    = F_LOW;
                    num_next   = '0;
                    den_next   = '0;
                    idx_next   = '0;
                    state_next = ACC;
                end
            end
            ACC: begin
                num_next = num_acc;
                den_next = den_acc;
                if (idx_reg == 4'd8) begin
                    rem_next   = num_acc;
                    q_next     = '0;
                    k_next     = 3'd7;
                    state_next = DIV;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end
            DIV: begin
                if (bit_set) begin
                    rem_next        = rem_reg - den_shift;
                    q_next[k_reg]   = 1'b1;
                end
                if (k_reg == 3'd0) begin
                    saida_next = q_next;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    k_next = k_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg <= IDLE;
            fu_reg    <= '0;
            fl_reg    <= '0;
            num_reg   <= '0;
            rem_reg   <= '0;
            den_reg   <= '0;
            idx_reg   <= '0;
            k_reg     <= '0;
            q_reg     <= '0;
            saida_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            fu_reg    <= fu_next;
            fl_reg    <= fl_next;
            num_reg   <= num_next;
            rem_reg   <= rem_next;
            den_reg   <= den_next;
            idx_reg   <= idx_next;
            k_reg     <= k_next;
            q_reg     <= q_next;
            saida_reg <= saida_next;
            done_reg  <= done_next;
        end
    end

    assign Saida = saida_reg;
    assign DONE  = done_reg;
    assign BUSY  = (state_reg != IDLE);

endmodule

// File: tb/tb_defuzzificador_nie_tan.sv
// Directed bench: expected results are queued at START and matched against each DONE pulse.
module tb_defuzzificador_nie_tan;

    logic        clk = 1'b0;
    logic        RESET;
    logic        START;
    logic [71:0] F_UP;
    logic [71:0] F_LOW;
    logic [7:0]  Saida;
    logic        DONE;
    logic        BUSY;

    defuzzificador_nie_tan dut (
        .clk   (clk),
        .RESET (RESET),
        .START (START),
        .F_UP  (F_UP),
        .F_LOW (F_LOW),
        .Saida (Saida),
        .DONE  (DONE),
        .BUSY  (BUSY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Reference: weighted mean of the default centroids, truncated; zero weight gives 0.
    function automatic logic [7:0] model(input logic [71:0] fu, input logic [71:0] fl);
        int c[9] = '{0, 32, 64, 96, 128, 160, 192, 224, 255};
        int num = 0;
        int den = 0;
        for (int i = 0; i < 9; i++) begin
            int w;
            w   = int'(fu[8*i +: 8]) + int'(fl[8*i +: 8]);
            num += w * c[i];
            den += w;
        end
        if (den == 0) return 8'd0;
        return 8'(num / den);
    endfunction

    // Called at a negedge; the following posedge is the START edge, DONE shows 17 edges later.
    task automatic start_run(input logic [71:0] fu, input logic [71:0] fl, output int dc);
        exp_t e;
        F_UP  = fu;
        F_LOW = fl;
        START = 1'b1;
        dc    = cyc + 18;
        e.val = model(fu, fl);
        e.done_cyc = dc;
        sb.push_back(e);
        $display("start: cyc=%0d expect Saida=%0d at cyc=%0d", cyc, e.val, dc);
        @(negedge clk);
        START = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        check("busy_after_done", {31'd0, BUSY}, 0);
    endtask

    always @(negedge clk) begin
        if (!RESET && DONE !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, DONE}, 0);
            end else begin
                mon_e = sb.pop_front();
                $display("done: cyc=%0d Saida=%0d expected=%0d", cyc, Saida, mon_e.val);
                check("saida", {24'd0, Saida}, {24'd0, mon_e.val});
                check("latency", cyc, mon_e.done_cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [71:0] fu, fl;
    int dc_a, dc_b, guard;

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        F_UP  = '0;
        F_LOW = '0;
        repeat (3) @(negedge clk);
        check("reset_saida", {24'd0, Saida}, 0);
        check("reset_done",  {31'd0, DONE}, 0);
        check("reset_busy",  {31'd0, BUSY}, 0);
        RESET = 1'b0;
        @(negedge clk);

        // Single rule 5 at full strength
        fu = '0; fl = '0;
        fu[32 +: 8] = 8'd255; fl[32 +: 8] = 8'd255;
        start_run(fu, fl, dc_a);
        check("busy_in_acc", {31'd0, BUSY}, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("saida_hold", {24'd0, Saida}, 128);

        // Rules 1 and 9 blend, truncates 127.5
        fu = '0; fl = '0;
        fu[0 +: 8] = 8'd255; fl[0 +: 8] = 8'd255;
        fu[64 +: 8] = 8'd255; fl[64 +: 8] = 8'd255;
        start_run(fu, fl, dc_a);
        wait_idle();

        // All-zero firing
        start_run(72'd0, 72'd0, dc_a);
        wait_idle();

        // Interval weighting
        fu = '0; fl = '0;
        fu[8 +: 8] = 8'd200; fl[8 +: 8] = 8'd100;
        fu[16 +: 8] = 8'd100;
        start_run(fu, fl, dc_a);
        wait_idle();

        // START pulses during a run and input changes afterwards are ignored
        fu = '0; fl = '0;
        fu[24 +: 8] = 8'd90; fl[24 +: 8] = 8'd40;
        fu[56 +: 8] = 8'd180; fl[56 +: 8] = 8'd20;
        start_run(fu, fl, dc_a);
        repeat (3) @(negedge clk);
        F_UP = '1; F_LOW = {$urandom, $urandom, 8'hA5};
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        check("busy_cycle5", {31'd0, BUSY}, 1);
        repeat (6) @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        check("busy_cycle12", {31'd0, BUSY}, 1);
        wait_idle();

        // START held through the DONE cycle is accepted on the next edge
        fu = '0; fl = '0;
        fu[40 +: 8] = 8'd150; fl[40 +: 8] = 8'd150;
        fu[48 +: 8] = 8'd50;
        start_run(fu, fl, dc_a);
        guard = 0;
        while (cyc < dc_a && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        fu = '0; fl = '0;
        fu[16 +: 8] = 8'd77; fl[64 +: 8] = 8'd200;
        start_run(fu, fl, dc_b);
        wait_idle();

        // Reset during accumulation
        fu = '0; fl = '0;
        fu[32 +: 8] = 8'd255; fl[64 +: 8] = 8'd255;
        start_run(fu, fl, dc_a);
        repeat (5) @(negedge clk);
        RESET = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("rst_acc_busy",  {31'd0, BUSY}, 0);
        check("rst_acc_saida", {24'd0, Saida}, 0);
        check("rst_acc_done",  {31'd0, DONE}, 0);
        RESET = 1'b0;
        repeat (25) @(negedge clk);
        start_run(fu, fl, dc_a);
        wait_idle();

        // Reset during division
        start_run(fu, fl, dc_a);
        repeat (13) @(negedge clk);
        RESET = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("rst_div_busy",  {31'd0, BUSY}, 0);
        check("rst_div_saida", {24'd0, Saida}, 0);
        check("rst_div_done",  {31'd0, DONE}, 0);
        RESET = 1'b0;
        repeat (25) @(negedge clk);
        fu = '0; fl = '0;
        fu[8 +: 8] = 8'd200; fl[8 +: 8] = 8'd100;
        fu[16 +: 8] = 8'd100;
        start_run(fu, fl, dc_a);
        wait_idle();

        // Random firing intervals
        for (int r = 0; r < 6; r++) begin
            fu = {$urandom, $urandom, 8'($urandom)};
            fl = {$urandom, $urandom, 8'($urandom)};
            start_run(fu, fl, dc_a);
            wait_idle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/defuzzificador_nie_tan.md
# defuzzificador_nie_tan

Sequential output stage of the interval type-2 fuzzy controller, sitting after rule inference: it accepts the nine rule firing intervals (upper/lower degree per rule, built from the fuzzifier's FOU outputs) and reduces them to one crisp 8-bit control value. It uses the Nie-Tan closed-form type reduction, y = Σ((fU_i+fL_i)·C_i) / Σ(fU_i+fL_i). The datapath is one multiply-accumulate per cycle followed by an 8-step restoring divider, with a fixed latency of 17 cycles.

## Interface
- C1..C9, defaults 0, 32, 64, 96, 128, 160, 192, 224, 255 — 8-bit consequent centroids of rules 1..9, overridable by defparam.
- clk  in  1  — single clock, all state on rising edge.
- RESET  in  1  — synchronous, active-high reset.
- START  in  1  — request; sampled only in IDLE.
- F_UP  in  72  — upper firing degrees; rule i (1..9) at bits [8i-1:8i-8].
- F_LOW  in  72  — lower firing degrees, same packing.
- Saida  out  8  — crisp output; holds last result.
- DONE  out  1  — one-cycle pulse when Saida updates.
- BUSY  out  1  — high in ACC and DIV.

## Operation
- Reset value on RESET=1 at an edge: state=IDLE, Saida=0, DONE=0, BUSY=0, accumulators, index, and quotient cleared. Reset takes effect in any state, including mid-ACC or mid-DIV. The aborted result is discarded and no DONE is issued.
- FSM: IDLE → ACC → DIV → IDLE.
  - IDLE with START=1: register F_UP/F_LOW into internal copies, clear NUM/DEN, set idx=0, go to ACC.
  - IDLE with START=0: stay in IDLE.
  - ACC, 9 cycles, idx 0..8:
    - w = fU[idx] + fL[idx], 9 bits, no overflow.
    - NUM += w·C[idx+1]; NUM is 21 bits, max 9·510·255 = 1 170 450.
    - DEN += w; DEN is 13 bits.
    - After idx=8: load remainder R=NUM, set q=0, set bit counter k=7, go to DIV.
  - DIV, 8 cycles, k=7..0: if R ≥ (DEN<<k), then R −= DEN<<k and q[k]=1. The quotient always fits 8 bits because it is a weighted mean of 8-bit centroids.
  - At k=0: Saida ← q (truncated, no rounding), DONE=1 for that cycle, go to IDLE.
- DEN==0 (all firing degrees zero): DIV still runs its full 8 cycles and Saida ← 0. Latency is unchanged.
- START while BUSY=1 is ignored; it is neither queued nor allowed to corrupt state.
- Inputs only need to be valid at the START sampling edge. Changes afterward do not affect the result.
- fU<fL is not checked; the sum is used as given.

## Timing
- START sampled high at edge 0 in IDLE.
- Edges 1–9 perform accumulation; edges 10–17 perform division.
- At edge 17 Saida updates and DONE rises; DONE falls at edge 18.
- BUSY is high from after edge 0 to after edge 17.
- Latency is 17 cycles from the START edge to Saida/DONE, regardless of data.
- IDLE is re-entered at edge 17, so START=1 during the DONE cycle is accepted at edge 18. Back-to-back throughput is one result per 18 cycles.
- Saida is stable between DONE pulses.

## Test plan
- Single rule: rule 5 fU=fL=255, all others 0, default C → Saida=128, DONE exactly 17 cycles after START.
- Two-rule blend: rule 1 and rule 9 fU=fL=255, others 0 → NUM=130050, DEN=1020, Saida=127 (truncation of 127.5).
- All-zero firing: F_UP=F_LOW=0 → Saida=0, DONE still at cycle 17, no X on outputs.
- Interval weighting: rule 2 fU=200/fL=100 (w=300), rule 3 fU=100/fL=0 (w=100) → (300·32+100·64)/400 = 40.
- Handshake: START pulses at cycles 5 and 12 of a run are ignored. START held in the DONE cycle gives a second DONE 18 cycles after the first. Inputs changed after the START edge do not alter the result.
- Reset mid-operation: RESET at cycle 6 (ACC) and again at cycle 14 (DIV) of separate runs → next cycle state IDLE, Saida=0, BUSY=0, no DONE. A following START produces a correct result.
